// File: rtl/regfile_dump.sv
// regfile_dump
//   Debug reader for the 32x32 integer register file. A start pulse walks
//   x0..xLAST_REG through a dedicated combinational read port and streams
//   each 32-bit word, LSB first, onto a valid/ready byte interface that
//   feeds the UART transmitter. Never writes the register file.
//
//   Optional feature macro: REGDUMP_INDEX_EN
//     defined   -> each word is preceded by an index byte {3'b0, idx}
//     undefined -> raw words only, 4 bytes per register
//
// Parameters
//   LAST_REG   highest register index dumped (0..31)
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      dump request, only sampled in IDLE
//   busy       high from LOAD of x0 through the done cycle
//   done       one-cycle pulse after the last byte is accepted
//   rd_reg     register-file read address (the index counter)
//   rd_data    register-file read data, combinational from rd_reg
//   tx_data    byte to transmit
//   tx_valid   tx_data is valid
//   tx_ready   sink accepts the byte when tx_valid is also high
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; nothing driven on the byte stream
// LOAD  | snapshot rd_data for the current index into shift
// IDX   | present index byte (REGDUMP_INDEX_EN only)
// SEND  | present shift[7:0]; four handshakes per word
// DONE  | one-cycle done pulse, then back to IDLE

module regfile_dump #(
    parameter int LAST_REG = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rd_reg,
    input  logic [31:0] rd_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

`ifdef REGDUMP_INDEX_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_IDX  = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;
`endif

    localparam logic [4:0] LAST_IDX = 5'(LAST_REG);

    state_t      state, state_nxt;
    logic [4:0]  index, index_nxt;
    logic [31:0] shift, shift_nxt;
    logic [1:0]  byte_cnt, byte_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            index    <= 5'd0;
            shift    <= 32'd0;
            byte_cnt <= 2'd0;
        end else begin
            state    <= state_nxt;
            index    <= index_nxt;
            shift    <= shift_nxt;
            byte_cnt <= byte_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        index_nxt    = index;
        shift_nxt    = shift;
        byte_cnt_nxt = byte_cnt;
        busy         = 1'b1;
        done         = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'd0;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    index_nxt = 5'd0;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                // Word is frozen here; later core writes are not seen.
                shift_nxt    = rd_data;
                byte_cnt_nxt = 2'd0;
`ifdef REGDUMP_INDEX_EN
                state_nxt    = S_IDX;
`else
                state_nxt    = S_SEND;
`endif
            end
`ifdef REGDUMP_INDEX_EN
            S_IDX: begin
                tx_valid = 1'b1;
                tx_data  = {3'b000, index};
                if (tx_ready) begin
                    state_nxt = S_SEND;
                end
            end
`endif
            S_SEND: begin
                tx_valid = 1'b1;
                tx_data  = shift[7:0];
                if (tx_ready) begin
                    shift_nxt    = shift >> 8;
                    byte_cnt_nxt = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        if (index == LAST_IDX) begin
                            state_nxt = S_DONE;
                        end else begin
                            index_nxt = index + 5'd1;
                            state_nxt = S_LOAD;
                        end
                    end
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign rd_reg = index;

endmodule
